// File: rtl/program_counter.sv
// Loadable program counter for the timer sequencer. It supports reset-to-vector,
// parallel load and increment, and the reset vector is a live input.
module program_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ResetVal,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] PCoutput
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;

  // Load takes precedence over increment. Increment wraps modulo 2^WIDTH.
  always_comb begin
    w_pc_next = r_pc;
    if (load)
      w_pc_next = LoadVal;
    else if (inc)
      w_pc_next = r_pc + WIDTH'(1);
  end

  // Every rising edge during reset re-samples the vector.
  // On release, the counter therefore starts from the last vector sampled at an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_pc <= ResetVal;
    else
      r_pc <= w_pc_next;
  end

  // While reset is asserted, the output follows the vector combinationally.
  // It does this immediately and without a clock.
  assign PCoutput = reset ? r_pc : ResetVal;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter.
// A reference model pushes the expected PC as stimulus is driven, and the value is popped when the DUT output is sampled.
module tb_program_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ResetVal;
  logic [7:0] LoadVal;
  logic       load;
  logic       inc;
  logic [7:0] PCoutput;

  logic [7:0] model_pc;
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  program_counter #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .ResetVal (ResetVal),
    .LoadVal  (LoadVal),
    .load     (load),
    .inc      (inc),
    .PCoutput (PCoutput)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, obs);
    end
  endtask

  // Pops one expected value and compares it against the current DUT output.
  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, PCoutput, e);
    end
  endtask

  // Drives one cycle of inputs at the falling edge.
  // The model predicts the post-edge value, which is checked just after the rising edge.
  task automatic cycle(input string tag, input logic rst_n, input logic ld, input logic in,
                       input logic [7:0] lv, input logic [7:0] rv);
    @(negedge clk);
    reset = rst_n; load = ld; inc = in; LoadVal = lv; ResetVal = rv;
    if (!rst_n)  model_pc = rv;
    else if (ld) model_pc = lv;
    else if (in) model_pc = model_pc + 8'd1;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  // Changes the vector while reset is held low, then checks the output with no clock edge in between.
  task automatic reset_vec_check(input string tag, input logic [7:0] rv);
    ResetVal = rv;
    model_pc = rv;
    exp_q.push_back(rv);
    #1;
    pop_check(tag);
  endtask

  initial begin
    logic [7:0] rv;
    reset = 1'b0; ResetVal = 8'h00; LoadVal = 8'h55; load = 1'b1; inc = 1'b1;
    model_pc = 8'h00;
    exp_q.push_back(8'h00);
    #1;
    pop_check("reset_t0");
    cycle("reset_edge0", 1'b0, 1'b1, 1'b1, 8'h55, 8'h00);
    @(negedge clk);
    reset_vec_check("reset_track01", 8'h01);
    cycle("reset_edge1", 1'b0, 1'b1, 1'b1, 8'h55, 8'h01);

    // Release reset between edges.
    // The output should switch to the sampled vector at once.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; inc = 1'b1; LoadVal = 8'h91;
    exp_q.push_back(8'h01);
    #1;
    pop_check("release_immediate");
    model_pc = 8'h91;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    pop_check("load_91");
    cycle("load_91_hold", 1'b1, 1'b1, 1'b1, 8'h91, 8'h01);
    cycle("load_9D", 1'b1, 1'b1, 1'b1, 8'h9D, 8'h01);

    for (int i = 0; i < 10; i++)
      cycle($sformatf("inc_run%0d", i), 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);

    for (int i = 0; i < 3; i++)
      cycle($sformatf("reload01_%0d", i), 1'b1, 1'b1, 1'b1, 8'h01, 8'h01);
    for (int i = 0; i < 4; i++)
      cycle($sformatf("count_%0d", i), 1'b1, 1'b0, 1'b1, 8'h01, 8'h01);

    for (int i = 0; i < 4; i++)
      cycle($sformatf("hold_%0d", i), 1'b1, 1'b0, 1'b0, 8'h00, 8'h01);

    cycle("load_FF", 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01);
    cycle("wrap_00", 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);
    cycle("inc_01", 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);

    // Assert reset in the middle of the sequence.
    // It must override both load and inc.
    cycle("mid_reset", 1'b0, 1'b1, 1'b1, 8'h77, 8'h3C);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rv = 8'($urandom_range(0, 255));
      reset_vec_check($sformatf("reset_sweep%0d", i), rv);
    end

    cycle("sweep_edge", 1'b0, 1'b0, 1'b1, 8'h00, 8'hC4);
    cycle("post_release_inc", 1'b1, 1'b0, 1'b1, 8'h00, 8'hC4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

8-bit loadable program counter for the two-mode timer sequencer. It holds the current instruction/step address and drives it to the fetch logic. It is updated on the rising clock edge by, in priority order, reset-to-vector, parallel load, and increment. The reset vector is a live input rather than a constant, so a boot/mode selector can choose the start address.

## Interface
- WIDTH, default 8: counter, reset-vector and load-value width.

- clk  input  1: system clock; all state changes on the rising edge except reset assertion.
- reset  input  1: asynchronous, active-low reset. 0 = reset asserted.
- ResetVal  input  WIDTH: reset vector, the value the PC takes under reset.
- LoadVal  input  WIDTH: parallel load value.
- load  input  1: synchronous load enable, active-high.
- inc  input  1: synchronous increment enable, active-high.
- PCoutput  output  WIDTH: current program-counter value.

## Operation
- Internal register pc_q, WIDTH bits.
- Priority per rising edge: reset > load > inc > hold.
  - reset=0: pc_q <= ResetVal.
  - reset=1, load=1: pc_q <= LoadVal. Increment is suppressed even if inc=1.
  - reset=1, load=0, inc=1: pc_q <= pc_q + 1, modulo 2^WIDTH. 0xFF wraps to 0x00 with no flag or carry out.
  - reset=1, load=0, inc=0: pc_q holds.
- Output: PCoutput = ResetVal while reset=0, otherwise PCoutput = pc_q.
  - The reset-side path is combinational, so assertion takes effect immediately, asynchronous to clk.
  - While reset is held low, PCoutput tracks every change of ResetVal with no clock needed.
- ResetVal, LoadVal, load and inc are sampled only at rising edges, apart from the combinational reset path above. Between edges they have no effect on pc_q.
- No X-propagation handling is required. Inputs are assumed driven.

## Timing
- Reset value of PCoutput is ResetVal, not a constant, and is valid immediately on reset assertion.
- Reset release:
  - pc_q holds the ResetVal sampled at the last rising edge during reset.
  - ResetVal must be stable for at least one rising edge before reset is released.
  - Releasing reset between edges changes PCoutput to pc_q at once.
- Load latency: 1 cycle. LoadVal at edge N appears on PCoutput just after edge N.
- Increment latency: 1 cycle. One increment per edge while inc=1 and load=0.
- Holding load high reloads every cycle. A LoadVal change while load=1 appears at the next edge.
- Dropping load with inc=1: the first increment happens at the next edge, starting from the last loaded value.
- Reset asserted mid-sequence overrides load/inc immediately and on all edges while asserted.
- Relative input timing:
  - Inputs must meet setup/hold to clk.
  - The testbench changes inputs at the falling edge (10 ns period, clk starts low).

## Test plan
- Reset tracks vector: reset=0, ResetVal=0x00, load=inc=1, then ResetVal=0x01 without releasing reset -> PCoutput=0x00, then 0x01 immediately; load/inc ignored.
- Load beats inc:
  - Steps: release reset with load=1, inc=1, LoadVal=0x91.
  - Required: PCoutput=0x91 after the next edge and stays 0x91.
  - Then LoadVal=0x9D -> PCoutput=0x9D after one edge, no increments.
- Increment run: load=0, inc=1 from 0x9D for 10 edges -> 0x9E, 0x9F, …, 0xA7, one step per edge.
- Reload then count:
  - Steps: load=1, LoadVal=0x01 for 3 edges, then load=0 for 4 edges.
  - Required: 0x01 held for the 3 load edges, then 0x02, 0x03, 0x04, 0x05.
- Hold: inc=0, load=0 for 4 edges -> PCoutput stays 0x05. Also wrap: load 0xFF, then inc -> 0x00.
- Reset sweep: reset=0, 8 random ResetVal values changed every 10 ns -> PCoutput equals each ResetVal within the same time step.
